// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder; err_o exists only with INSTR_ENCODER_ERR_EN.
// Modport slave is the encoder itself, modport master is the surrounding producer/consumer.
`timescale 1ns/1ps
interface instr_encoder_if #(
   parameter int DEPTH = 4
) ();
   localparam int LW = $clog2(DEPTH) + 1;

   logic          in_valid_i;
   logic          in_ready_o;
   logic [2:0]    kind_i;
   logic [4:0]    rd_i;
   logic [4:0]    rs1_i;
   logic [4:0]    rs2_i;
   logic [2:0]    funct3_i;
   logic [6:0]    funct7_i;
   logic [12:0]   imm_i;
   logic          out_valid_o;
   logic          out_ready_i;
   logic [31:0]   instr_o;
   logic [LW-1:0] level_o;
   logic [15:0]   count_o;
`ifdef INSTR_ENCODER_ERR_EN
   logic          err_o;

   modport slave (
      input  in_valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
      output in_ready_o, out_valid_o, instr_o, level_o, count_o, err_o
   );
   modport master (
      output in_valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
      input  in_ready_o, out_valid_o, instr_o, level_o, count_o, err_o
   );
`else
   modport slave (
      input  in_valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
      output in_ready_o, out_valid_o, instr_o, level_o, count_o
   );
   modport master (
      output in_valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i, out_ready_i,
      input  in_ready_o, out_valid_o, instr_o, level_o, count_o
   );
`endif
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a DEPTH-entry FIFO; one-cycle latency, no pass-through,
// in_ready low whenever full. INSTR_ENCODER_ERR_EN drops illegal kinds and raises sticky err_o.
`timescale 1ns/1ps
module instr_encoder #(
   parameter int DEPTH = 4
) (
   input  logic           clk_i,
   input  logic           rst_i,
   instr_encoder_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [LW-1:0] level;
   logic [15:0]   count;
   logic [31:0]   enc_word;
   logic          legal;
   logic          in_ready;
   logic          out_valid;
   logic          accept;
   logic          write;
   logic          pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_comb begin
      enc_word = NOP_WORD;
      legal    = 1'b1;
      case (bus.kind_i)
         3'd0: enc_word = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i, bus.rd_i, OP_R};
         3'd1: enc_word = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i, bus.rd_i, OP_I};
         3'd2: enc_word = {bus.imm_i[11:0], bus.rs1_i, 3'b010, bus.rd_i, OP_LOAD};
         3'd3: enc_word = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i, 3'b010,
                           bus.imm_i[4:0], OP_STORE};
         // Branch offsets are even, so imm_i[0] has no slot in the word.
         3'd4: enc_word = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i, bus.rs1_i, 3'b000,
                           bus.imm_i[4:1], bus.imm_i[11], OP_BRANCH};
         default: legal = 1'b0;
      endcase
   end

   assign in_ready  = (level != LW'(DEPTH));
   assign out_valid = (level != '0);
   assign accept    = bus.in_valid_i && in_ready;
   assign pop       = out_valid && bus.out_ready_i;
`ifdef INSTR_ENCODER_ERR_EN
   assign write     = accept && legal;
`else
   assign write     = accept;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (write) begin
            mem[wptr] <= enc_word;
            wptr      <= ptr_inc(wptr);
         end
         if (pop) begin
            rptr  <= ptr_inc(rptr);
            count <= count + 16'd1;
         end
         if (write && !pop) begin
            level <= level + LW'(1);
         end else if (!write && pop) begin
            level <= level - LW'(1);
         end
      end
   end

`ifdef INSTR_ENCODER_ERR_EN
   logic err;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err <= 1'b0;
      end else if (accept && !legal) begin
         err <= 1'b1;
      end
   end

   assign bus.err_o = err;
`endif

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.instr_o     = mem[rptr];
   assign bus.level_o     = level;
   assign bus.count_o     = count;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, output FIFO entries; power of two, 2..16.
REQ-002 clk_i  in  1  sole clock, rising edge.
REQ-003 rst_i  in  1  asynchronous active-low reset.
REQ-004 in_valid_i  in  1  request present.
REQ-005 in_ready_o  out  1  encoder can accept request.
REQ-006 kind_i  in  3  0=R-ALU, 1=I-ALU, 2=LOAD, 3=STORE, 4=BRANCH, 5..7 illegal.
REQ-007 rd_i, rs1_i, rs2_i  in  5 each  register indices.
REQ-008 funct3_i  in  3 / funct7_i  in  7  ALU function fields.
REQ-009 imm_i  in  13  signed immediate; bits used per kind.
REQ-010 out_valid_o  out  1  instr_o holds valid word.
REQ-011 out_ready_i  in  1  consumer accepts word.
REQ-012 instr_o  out  32  encoded RV32I instruction word.
REQ-013 level_o  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-014 count_o  out  16  total words popped, modulo 2^16.

Function
REQ-015 Accept on in_valid_i && in_ready_o; pop on out_valid_o && out_ready_i.
REQ-016 Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
REQ-017 R: {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode}.
REQ-018 I: {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode}.
REQ-019 LOAD: as I with funct3 forced 010; funct3_i ignored.
REQ-020 STORE: {imm_i[11:5], rs2_i, rs1_i, 010, imm_i[4:0], opcode}.
REQ-021 BRANCH: {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 000, imm_i[4:1], imm_i[11], opcode}; imm_i[0] ignored.
REQ-022 Encoding combinational at input; encoded word written into FIFO on accept.
REQ-023 FIFO: circular, write/read pointers wrap DEPTH-1 -> 0; instr_o = head entry, registered storage.
REQ-024 Latency: word accepted in cycle N into empty FIFO appears with out_valid_o=1 in cycle N+1; no same-cycle pass-through.
REQ-025 out_valid_o = (level_o != 0); in_ready_o = (level_o != DEPTH).
REQ-026 Full: in_ready_o=0 even if pop occurs same cycle; level unchanged by pop-only-when-full until next cycle.
REQ-027 Simultaneous push and pop when 0 < level < DEPTH: level unchanged, both pointers advance.
REQ-028 Empty: pop impossible; instr_o holds last head value, don't-care.
REQ-029 instr_o stable while out_valid_o=1 and out_ready_i=0.
REQ-030 count_o increments by 1 per pop; 16'hFFFF wraps to 0.
REQ-031 Illegal kind (5..7), macro absent: accepted and encoded as 32'h00000013 (NOP).

Reset
REQ-032 rst_i low asynchronously clears pointers, level_o=0, count_o=0, out_valid_o=0, in_ready_o=1, instr_o=0, err_o=0.
REQ-033 Reset mid-operation discards all buffered words; no partial word survives.
REQ-034 First accept permitted on first rising edge after rst_i deasserts.

Configuration
REQ-035 Macro INSTR_ENCODER_ERR_EN.
REQ-036 Defined: port err_o (out, 1) added; illegal kind accepted but not written to FIFO; err_o set sticky next cycle, cleared only by reset.
REQ-037 Undefined: no err_o port; REQ-031 applies.

Verification
REQ-038 R: kind=0, funct7=0100000, rs2=3, rs1=2, funct3=000, rd=1 -> instr_o=32'h403100B3 one cycle after accept.
REQ-039 LOAD: kind=2, imm=8, rs1=2, rd=5, funct3_i=111 -> 32'h00812283; STORE kind=3, imm=12, rs2=5, rs1=2 -> 32'h00512623.
REQ-040 BRANCH: kind=4, imm=-8 (13'h1FF8), rs1=1, rs2=2 -> 32'hFE208CE3.
REQ-041 Fill: out_ready_i=0, push 5 requests -> 4 accepted, in_ready_o=0, level_o=4; release -> words in order, count_o=4.
REQ-042 Reset with level_o=3 -> level_o=0, out_valid_o=0 immediately, count_o=0; preload count 16'hFFFF then pop -> 0.
REQ-043 Illegal kind=6: macro off -> 32'h00000013 emitted; macro on -> nothing emitted, err_o=1 stays high.
